pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Carries PC, instruction, destination register address and NUM_DATA payload words of DATA_W bits between two CPU pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer so `in_ready` is fully registered, a flush that inserts a bubble, and ordered, lossless transfer under back-pressure.
- Drop-in for any stage boundary: D/E, E/M or M/W.

---
 rtl/pipe_skid_stage.sv | 160 ++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a 2-entry skid buffer.
// Carries PC, instruction, destination register and NUM_DATA payload words
// between two CPU stages. in_ready is driven straight from a flop.
// A flush empties the stage and zeroes both entries, which leaves a nop bubble.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to build the saturating
// back-pressure counter on stall_cnt. When it is undefined, stall_cnt is 0.
module pipe_skid_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_DATA = 2,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic [DATA_W*NUM_DATA-1:0] in_data,
  input  logic [ADDR_W-1:0]          in_regaddr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [DATA_W*NUM_DATA-1:0] out_data,
  output logic [ADDR_W-1:0]          out_regaddr,
  output logic [31:0]                stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                      r_state;
  logic                        r_in_ready;
  logic                        r_out_valid;

  logic [31:0]                 r_main_pc;
  logic [31:0]                 r_main_instr;
  logic [DATA_W*NUM_DATA-1:0]  r_main_data;
  logic [ADDR_W-1:0]           r_main_regaddr;

  logic [31:0]                 r_skid_pc;
  logic [31:0]                 r_skid_instr;
  logic [DATA_W*NUM_DATA-1:0]  r_skid_data;
  logic [ADDR_W-1:0]           r_skid_regaddr;

  logic                        w_accept;
  logic                        w_pop;

  // Handshake qualifiers for this cycle
  always_comb begin
    w_accept = in_valid & r_in_ready;
    w_pop    = r_out_valid & out_ready;
  end

  // Occupancy FSM; the state, in_ready, out_valid and both entries are all registered here
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_main_pc      <= '0;
      r_main_instr   <= '0;
      r_main_data    <= '0;
      r_main_regaddr <= '0;
      r_skid_pc      <= '0;
      r_skid_instr   <= '0;
      r_skid_data    <= '0;
      r_skid_regaddr <= '0;
    end else if (flush) begin
      // Flush beats any accept or pop happening in the same cycle
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_main_pc      <= '0;
      r_main_instr   <= '0;
      r_main_data    <= '0;
      r_main_regaddr <= '0;
      r_skid_pc      <= '0;
      r_skid_instr   <= '0;
      r_skid_data    <= '0;
      r_skid_regaddr <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_pc      <= in_pc;
            r_main_instr   <= in_instr;
            r_main_data    <= in_data;
            r_main_regaddr <= in_regaddr;
            r_out_valid    <= 1'b1;
            r_state        <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main_pc      <= in_pc;
            r_main_instr   <= in_instr;
            r_main_data    <= in_data;
            r_main_regaddr <= in_regaddr;
          end else if (w_accept) begin
            // The main entry is held, so the new entry goes into the skid slot
            r_skid_pc      <= in_pc;
            r_skid_instr   <= in_instr;
            r_skid_data    <= in_data;
            r_skid_regaddr <= in_regaddr;
            r_in_ready     <= 1'b0;
            r_state        <= ST_TWO;
          end else if (w_pop) begin
            r_out_valid    <= 1'b0;
            r_state        <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_main_pc      <= r_skid_pc;
            r_main_instr   <= r_skid_instr;
            r_main_data    <= r_skid_data;
            r_main_regaddr <= r_skid_regaddr;
            r_in_ready     <= 1'b1;
            r_state        <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count the edges where downstream refuses a valid entry; saturates, cleared only by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'h0;
`endif

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_main_pc;
  assign out_instr   = r_main_instr;
  assign out_data    = r_main_data;
  assign out_regaddr = r_main_regaddr;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage with the default parameters.
module tb_pipe_skid_stage;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_DATA = 2;
  localparam int unsigned ADDR_W   = 5;

  logic                       Clk;
  logic                       Reset;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_pc;
  logic [31:0]                in_instr;
  logic [DATA_W*NUM_DATA-1:0] in_data;
  logic [ADDR_W-1:0]          in_regaddr;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_pc;
  logic [31:0]                out_instr;
  logic [DATA_W*NUM_DATA-1:0] out_data;
  logic [ADDR_W-1:0]          out_regaddr;
  logic [31:0]                stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_skid_stage #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_data     (in_data),
    .in_regaddr  (in_regaddr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_data    (out_data),
    .out_regaddr (out_regaddr),
    .stall_cnt   (stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge; inputs and checks happen 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drive an upstream entry whose fields all derive from the PC
  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = pc ^ 32'hA5A5_0000;
    in_data    = {pc + 32'h100, pc + 32'h200};
    in_regaddr = pc[6:2];
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    flush = 0; out_ready = 0;
    drive(1'b0, 32'h0);
    Reset = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    n_checks++; if (out_data !== 64'h0) begin n_errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_checks++; if (stall_cnt !== 32'h0) begin n_errors++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1;
    drive(1'b1, 32'h3000);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin n_errors++; $display("FAIL stream_0 got v=%0h pc=%h exp v=1 pc=3000", out_valid, out_pc); end
    n_checks++; if (out_data !== 64'h0000_3100_0000_3200) begin n_errors++; $display("FAIL stream_0_data got %h exp 0000310000003200", out_data); end
    n_checks++; if (out_instr !== 32'hA5A5_3000 || out_regaddr !== 5'd0) begin n_errors++; $display("FAIL stream_0_fields got instr=%h ra=%0d exp a5a53000 0", out_instr, out_regaddr); end
    drive(1'b1, 32'h3004);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_regaddr !== 5'd1) begin n_errors++; $display("FAIL stream_1 got v=%0h pc=%h ra=%0d exp v=1 pc=3004 ra=1", out_valid, out_pc, out_regaddr); end
    drive(1'b1, 32'h3008);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3008 || in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_2 got v=%0h pc=%h rdy=%0h exp v=1 pc=3008 rdy=1", out_valid, out_pc, in_ready); end
    drive(1'b0, 32'h0);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain got v=%0h exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(1'b1, 32'h3000);
    step();
    n_checks++; if (out_pc !== 32'h3000 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_one got pc=%h rdy=%0h exp 3000 1", out_pc, in_ready); end
    drive(1'b1, 32'h3004);
    step();
    n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_two got rdy=%0h pc=%h v=%0h exp 0 3000 1", in_ready, out_pc, out_valid); end
    drive(1'b1, 32'h3008);
    step();
    n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_data !== 64'h0000_3100_0000_3200) begin n_errors++; $display("FAIL bp_hold got rdy=%0h pc=%h data=%h exp 0 3000 0000310000003200", in_ready, out_pc, out_data); end
    out_ready = 1;
    step();
    n_checks++; if (out_pc !== 32'h3004 || in_ready !== 1'b1 || out_instr !== 32'hA5A5_3004) begin n_errors++; $display("FAIL bp_release1 got pc=%h rdy=%0h instr=%h exp 3004 1 a5a53004", out_pc, in_ready, out_instr); end
    step();
    n_checks++; if (out_pc !== 32'h3008 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_release2 got pc=%h v=%0h exp 3008 1", out_pc, out_valid); end
    drive(1'b0, 32'h0);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got v=%0h exp 0", out_valid); end
  endtask

  task automatic test_accept_pop();
    out_ready = 0;
    drive(1'b1, 32'h3000);
    step();
    drive(1'b1, 32'h3004);
    out_ready = 1;
    step();
    n_checks++; if (out_pc !== 32'h3004 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_errors++; $display("FAIL accpop got pc=%h v=%0h rdy=%0h exp 3004 1 1", out_pc, out_valid, in_ready); end
    drive(1'b0, 32'h0);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL accpop_drain got v=%0h exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1'b1, 32'h5000);
    step();
    drive(1'b1, 32'h5004);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_pre got rdy=%0h exp 0", in_ready); end
    drive(1'b1, 32'h4000);
    flush = 1;
    step();
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin n_errors++; $display("FAIL flush got v=%0h instr=%h rdy=%0h pc=%h exp 0 0 1 0", out_valid, out_instr, in_ready, out_pc); end
    flush = 0;
    drive(1'b0, 32'h0);
    out_ready = 1;
    step();
    n_checks++; if (out_valid !== 1'b0 || out_pc === 32'h4000) begin n_errors++; $display("FAIL flush_after got v=%0h pc=%h exp v=0 pc!=4000", out_valid, out_pc); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    drive(1'b1, 32'h6000);
    step();
    drive(1'b1, 32'h6004);
    step();
    drive(1'b0, 32'h0);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid got v=%0h pc=%h instr=%h rdy=%0h exp 0 0 0 1", out_valid, out_pc, out_instr, in_ready); end
    #1;
    Reset = 1'b0;
    out_ready = 1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid_skid got v=%0h exp 0", out_valid); end
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_stall;
`ifdef PIPE_SKID_STALL_CNT_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    do_reset();
    out_ready = 0;
    drive(1'b1, 32'h7000);
    step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 7; i++) step();
    n_checks++; if (stall_cnt !== exp_stall) begin n_errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    flush = 1;
    out_ready = 1;
    step();
    flush = 0;
    step();
    n_checks++; if (stall_cnt !== exp_stall) begin n_errors++; $display("FAIL stall_cnt_flush got %0d exp %0d", stall_cnt, exp_stall); end
    do_reset();
    n_checks++; if (stall_cnt !== 32'h0) begin n_errors++; $display("FAIL stall_cnt_reset got %0d exp 0", stall_cnt); end
  endtask

  initial begin
    Reset = 0; flush = 0; out_ready = 0;
    drive(1'b0, 32'h0);
    #2;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_accept_pop();
    test_flush();
    test_reset_midstream();
    test_stall_cnt();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
